// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for the VGA path.
// Produces pixel/line counters, the visible flag and line/frame strobes for
// the pattern generator, plus hsync/vsync delayed by SYNC_DELAY enabled
// cycles so the sync edges line up with the generator's registered RGB.
module vga_timing_gen #(
    parameter int          H_VISIBLE   = 640,
    parameter int          H_FRONT     = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BACK      = 48,
    parameter int          V_VISIBLE   = 480,
    parameter int          V_FRONT     = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BACK      = 33,
    parameter logic        SYNC_ACTIVE = 1'b0,
    parameter int unsigned SYNC_DELAY  = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ce,
    output logic [9:0] o_hpos,
    output logic [9:0] o_vpos,
    output logic       o_visible,
    output logic       o_line_strobe,
    output logic       o_frame_strobe,
    output logic       o_hsync,
    output logic       o_vsync
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]  HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]  VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0]  V_BLANK_AT = 10'(V_VISIBLE);
    localparam logic [10:0] H_VIS_LIM  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS_LIM  = 11'(V_VISIBLE);

    // Reject geometries the 10-bit counters cannot represent.
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || SYNC_DELAY > 4) begin : g_param_check
        $error("vga_timing_gen: totals must be <= 1024 and SYNC_DELAY <= 4");
    end

    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       raw_hsync;
    logic       raw_vsync;

    // Pixel/line counters; wrap on equality with total-1, hold when i_ce low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hpos <= '0;
            vpos <= '0;
        end else if (i_ce) begin
            if (hpos == H_LAST) begin
                hpos <= '0;
                if (vpos == V_LAST) begin
                    vpos <= '0;
                end else begin
                    vpos <= vpos + 10'd1;
                end
            end else begin
                hpos <= hpos + 10'd1;
            end
        end
    end

    // Position decode: visible area, strobes and undelayed sync levels.
    always_comb begin
        o_hpos         = hpos;
        o_vpos         = vpos;
        o_visible      = ({1'b0, hpos} < H_VIS_LIM) && ({1'b0, vpos} < V_VIS_LIM);
        o_line_strobe  = i_ce && (hpos == H_LAST);
        o_frame_strobe = i_ce && (hpos == '0) && (vpos == V_BLANK_AT);
        raw_hsync      = ((hpos >= HS_START) && (hpos <= HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        raw_vsync      = ((vpos >= VS_START) && (vpos <= VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    // Sync delay line; reset loads every stage inactive so the outputs drop
    // out of sync on the first reset edge rather than after SYNC_DELAY cycles.
    if (SYNC_DELAY == 0) begin : g_sync_direct
        assign o_hsync = raw_hsync;
        assign o_vsync = raw_vsync;
    end else if (SYNC_DELAY == 1) begin : g_sync_one
        logic hs_q;
        logic vs_q;

        // Single-stage sync register, advancing on enabled cycles only.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                hs_q <= ~SYNC_ACTIVE;
                vs_q <= ~SYNC_ACTIVE;
            end else if (i_ce) begin
                hs_q <= raw_hsync;
                vs_q <= raw_vsync;
            end
        end

        assign o_hsync = hs_q;
        assign o_vsync = vs_q;
    end else begin : g_sync_multi
        logic [SYNC_DELAY-1:0] hs_pipe;
        logic [SYNC_DELAY-1:0] vs_pipe;

        // Multi-stage sync shift register, advancing on enabled cycles only.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                hs_pipe <= {SYNC_DELAY{~SYNC_ACTIVE}};
                vs_pipe <= {SYNC_DELAY{~SYNC_ACTIVE}};
            end else if (i_ce) begin
                hs_pipe <= {hs_pipe[SYNC_DELAY-2:0], raw_hsync};
                vs_pipe <= {vs_pipe[SYNC_DELAY-2:0], raw_vsync};
            end
        end

        assign o_hsync = hs_pipe[SYNC_DELAY-1];
        assign o_vsync = vs_pipe[SYNC_DELAY-1];
    end

endmodule
